transpad_cmd_arb: RTL
=====================

// Module: transpad_cmd_arb
// PURPOSE
//  Shares one transpad_4x command port between NREQ requesters (cores/DMA agents).
//  - Round-robin arbitration: accepts at most one command per cycle.
//  - Per-unit ownership: the requester whose START is issued owns that unit until its STOP.
//  - Drives the transpad_4x command inputs from a register.
//  - Sits between the requester interconnect and transpad_4x.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  NUNIT  4   number of transpad units; unit index width UW = 2
//  CW     3   command width
//  DW     48  command data width
// PORTS
//  clk        in   1        clock, single domain
//  rst        in   1        reset, synchronous, active-high
//  req_valid  in   NREQ     requester i has a command pending
//  req_ready  out  NREQ     one-hot; requester i's command accepted this cycle
//  req_unit   in   NREQ*2   target unit, requester i at [i*2+1:i*2]
//  req_cmd    in   NREQ*CW  command, requester i at [i*CW+CW-1:i*CW]
//  req_data   in   NREQ*DW  command data, requester i at [i*DW+DW-1:i*DW]
//  resp_valid out  NREQ     one-hot; response for requester i
//  resp_err   out  1        qualifies resp_valid: 1 = command rejected, not issued
//  tp_unit    out  2        to transpad_4x unit
//  tp_rdy     out  1        to transpad_4x rdy
//  tp_cmd     out  CW       to transpad_4x cmd
//  tp_data    out  DW       to transpad_4x data
//  own_vld    out  NUNIT    unit u currently owned
//  own_id     out  NUNIT*3  owner index of unit u
// BEHAVIOUR
//  Reset values (rst high at an edge):
//   - all outputs 0
//   - RR pointer = 0
//   - ownership table cleared
//   - a command accepted in the cycle rst is high is dropped: no tp_rdy and no resp follow
//  Arbitration (combinational):
//   - grant = first req_valid at or after the pointer, scanning upward with wrap
//   - req_ready = grant, only when rst = 0
//   - requester holds valid/unit/cmd/data stable until req_ready
//   - on any accept, pointer <= grant index + 1 (mod NREQ); with no accept it holds
//  Check, evaluated in the accept cycle against the current table. Requester r, unit u:
//   - CMD_START, u free:              issue; own[u] <= r
//   - CMD_START, u owned by r:        issue (restart); table unchanged
//   - CMD_START, u owned by other:    reject
//   - CMD_STOP,  u owned by r:        issue; own[u] <= free
//   - CMD_STOP,  otherwise:           reject
//   - other cmd, u owned by r:        issue
//   - other cmd, otherwise:           reject
//  Issue timing:
//   - next cycle: tp_rdy = 1, with tp_unit/tp_cmd/tp_data = the accepted values
//   - resp_valid[r] = 1 and resp_err = 0 in that same cycle
//   - otherwise tp_rdy = 0 and tp_cmd/tp_data/tp_unit hold their last values
//  Reject timing:
//   - next cycle: resp_valid[r] = 1, resp_err = 1, tp_rdy = 0
//   - the reject still advances the pointer
//  Latency and throughput:
//   - accept-to-tp_rdy = 1 cycle
//   - back-to-back issues (tp_rdy high on consecutive cycles) are legal
//  Table updates:
//   - own_vld/own_id update at the same edge as tp_rdy
//   - the next accept already sees the new table: e.g. a STOP followed by another
//     requester's START to the same unit in the next cycle is granted
//  Table state per unit: 2 states, FREE and OWNED(id); no other state.
//  Fairness: with all requesters continuously valid, each is granted once every NREQ cycles.
// STRUCTURE
//  transpad_defs.vh (shared include, also used by transpad_cu/transpad_dp):
//   - CMD_START = 3'd1, CMD_STOP = 3'd2
//   - TP_UW = 2
//  Sub-module rr_arbiter #(N):
//   - ports: req[N], adv, gnt[N] one-hot; holds its own pointer
//   - advances only on adv
//  Top level: ownership table, check logic, output registers.
// TESTING
//  1. rst; r0 START u2, data = 48'h1 -> r0 ready at t0; t1: tp_rdy=1, tp_unit=2, tp_cmd=1,
//     resp_valid=0001, resp_err=0; own_vld=0100, own_id[u2]=0.
//  2. r1 START u2 while r0 owns u2 -> t1: resp_valid=0010, resp_err=1, tp_rdy=0; table unchanged.
//  3. All 4 requesters valid on distinct free units -> grants 0,1,2,3,0 on consecutive cycles;
//     tp_rdy high 4 cycles in a row; own_vld=1111.
//  4. r0 STOP u2, then r1 START u2 in the next cycle -> both issued, resp_err=0 both;
//     own_id[u2]=1.
//  5. r3 config cmd 3'd4 to unowned u0 -> rejected; STOP from a non-owner -> rejected.
//  6. rst asserted in an accept cycle -> next cycle tp_rdy=0, resp_valid=0, own_vld=0000,
//     next grant goes to r0.

Source files
------------

// File: rtl/transpad_cmd_arb_pkg.sv
// Shared definitions for the transpad command arbiter.
//  - Command encodings and unit index width used by transpad_4x.
//  - Owner id width (supports up to 8 requesters).
//  - Check outcome enum and a one-hot to index helper.
package transpad_cmd_arb_pkg;

  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;

  localparam int unsigned TP_UW = 2;
  localparam int unsigned ID_W  = 3;

  // Outcome of the ownership check for the accepted command.
  typedef enum logic [1:0] {
    ChkReject,
    ChkIssue,
    ChkIssueClaim,
    ChkIssueRelease
  } chk_e;

  // Index of the single set bit; 0 when no bit is set.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/transpad_cmd_arb_rr_arbiter.sv
// Round-robin arbiter (rr_arbiter).
//  clk  in  clock
//  rst  in  synchronous active-high reset, pointer returns to 0
//  req  in  N request lines
//  adv  in  grant was taken this cycle; pointer moves past the granted index
//  gnt  out one-hot grant: first request at or after the pointer, with wrap
module transpad_cmd_arb_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] scan_idx;
  logic          found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = PW'((32'(ptr_q) + i) % N);
      if (!found && req[scan_idx]) begin
        found         = 1'b1;
        gnt[scan_idx] = 1'b1;
        gnt_idx       = scan_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/transpad_cmd_arb.sv
// Command arbiter in front of transpad_4x.
// Shares the single transpad command port between NREQ requesters, enforcing
// per-unit ownership: the requester that STARTs a unit owns it until its STOP.
//  clk, rst    clock; synchronous active-high reset
//  req_valid   per-requester command pending
//  req_ready   one-hot accept (at most one per cycle)
//  req_unit    per-requester target unit, 2 bits each
//  req_cmd     per-requester command, CW bits each
//  req_data    per-requester data, DW bits each
//  resp_valid  one-hot response, one cycle after accept
//  resp_err    1 = accepted command was rejected and not issued
//  tp_unit/tp_rdy/tp_cmd/tp_data  registered transpad_4x command inputs
//  own_vld     per-unit owned flag
//  own_id      per-unit owner index, 3 bits each
module transpad_cmd_arb
  import transpad_cmd_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NUNIT = 4,
  parameter int unsigned CW    = 3,
  parameter int unsigned DW    = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*TP_UW-1:0] req_unit,
  input  logic [NREQ*CW-1:0]    req_cmd,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       resp_valid,
  output logic                  resp_err,
  output logic [TP_UW-1:0]      tp_unit,
  output logic                  tp_rdy,
  output logic [CW-1:0]         tp_cmd,
  output logic [DW-1:0]         tp_data,
  output logic [NUNIT-1:0]      own_vld,
  output logic [NUNIT*ID_W-1:0] own_id
);

  logic [NREQ-1:0]       gnt;
  logic                  accept;
  logic [ID_W-1:0]       sel_idx;
  logic [TP_UW-1:0]      sel_unit;
  logic [CW-1:0]         sel_cmd;
  logic [DW-1:0]         sel_data;
  logic                  cur_vld;
  logic [ID_W-1:0]       cur_id;
  logic                  is_owner;
  chk_e                  chk;

  logic [NREQ-1:0]       resp_valid_q;
  logic                  resp_err_q;
  logic [TP_UW-1:0]      tp_unit_q;
  logic                  tp_rdy_q;
  logic [CW-1:0]         tp_cmd_q;
  logic [DW-1:0]         tp_data_q;
  logic [NUNIT-1:0]      own_vld_q;
  logic [NUNIT*ID_W-1:0] own_id_q;

  transpad_cmd_arb_rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .adv (accept),
    .gnt (gnt)
  );

  // No accept during reset, so nothing accepted then can produce a response.
  assign accept    = !rst && (|gnt);
  assign req_ready = rst ? '0 : gnt;

  always_comb begin
    sel_idx  = onehot_to_idx(8'(gnt));
    sel_unit = req_unit[int'(sel_idx)*TP_UW +: TP_UW];
    sel_cmd  = req_cmd[int'(sel_idx)*CW +: CW];
    sel_data = req_data[int'(sel_idx)*DW +: DW];
    cur_vld  = own_vld_q[sel_unit];
    cur_id   = own_id_q[int'(sel_unit)*ID_W +: ID_W];
    is_owner = cur_vld && (cur_id == sel_idx);
  end

  always_comb begin
    chk = ChkReject;
    if (sel_cmd == CW'(CMD_START)) begin
      if (!cur_vld)     chk = ChkIssueClaim;
      else if (is_owner) chk = ChkIssue;
    end else if (sel_cmd == CW'(CMD_STOP)) begin
      if (is_owner) chk = ChkIssueRelease;
    end else if (is_owner) begin
      chk = ChkIssue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      tp_unit_q    <= '0;
      tp_rdy_q     <= 1'b0;
      tp_cmd_q     <= '0;
      tp_data_q    <= '0;
      own_vld_q    <= '0;
      own_id_q     <= '0;
    end else begin
      resp_valid_q <= accept ? gnt : '0;
      resp_err_q   <= accept && (chk == ChkReject);
      tp_rdy_q     <= accept && (chk != ChkReject);
      if (accept && (chk != ChkReject)) begin
        tp_unit_q <= sel_unit;
        tp_cmd_q  <= sel_cmd;
        tp_data_q <= sel_data;
      end
      if (accept && (chk == ChkIssueClaim)) begin
        own_vld_q[sel_unit]                          <= 1'b1;
        own_id_q[int'(sel_unit)*ID_W +: ID_W]        <= sel_idx;
      end
      if (accept && (chk == ChkIssueRelease)) begin
        own_vld_q[sel_unit]                          <= 1'b0;
        own_id_q[int'(sel_unit)*ID_W +: ID_W]        <= '0;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign tp_unit    = tp_unit_q;
  assign tp_rdy     = tp_rdy_q;
  assign tp_cmd     = tp_cmd_q;
  assign tp_data    = tp_data_q;
  assign own_vld    = own_vld_q;
  assign own_id     = own_id_q;

endmodule
